pipelined_addsub: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor. It succeeds the combinational N-bit ripple adder.
- The carry chain is split into STAGES equal chunks, with one register stage per chunk, so WIDTH scales without lengthening the critical path.
- Adds a subtract mode, carry/overflow flags and a valid/ready stream handshake.
- Sits between operand producers (ALU issue, accumulator datapaths) and result consumers that may back-pressure.

---
 rtl/pipelined_addsub_pkg.sv | 8 +
 rtl/pipelined_addsub_if.sv | 32 +++
 rtl/pipelined_addsub_chunk.sv | 37 +++
 rtl/pipelined_addsub.sv | 130 +++++++++++++
 tb/tb_pipelined_addsub.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
//   OP_ADD / OP_SUB : encoding of the op input (add = A+B+cin, sub = A-B).
package pipelined_addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result stream bundle for pipelined_addsub.
//   Operand side : in_valid/in_ready handshake, op, cin, a, b.
//   Result side  : out_valid/out_ready handshake, sum, cout, overflow.
//   master : the environment (operand producer and result consumer).
//   slave  : the adder block.
interface pipelined_addsub_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic             op;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, op, cin, a, b, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, op, cin, a, b, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );

endinterface

// File: rtl/pipelined_addsub_chunk.sv
// addsub_chunk: combinational CHUNK-bit ripple adder used once per stage.
//   i_a_chunk, i_b_chunk : operand slices (B already inverted for subtract)
//   i_c_in               : carry into bit 0 of the slice
//   o_s_chunk            : slice sum
//   o_c_out              : carry out of the slice MSB
//   o_c_msb              : carry into the slice MSB (for signed overflow)
module addsub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a_chunk,
  input  logic [CHUNK-1:0] i_b_chunk,
  input  logic             i_c_in,
  output logic [CHUNK-1:0] o_s_chunk,
  output logic             o_c_out,
  output logic             o_c_msb
);

  logic [CHUNK:0] w_c;

  // NOTE: every variable gets a default before the loop so no path leaves
  // it unassigned, which is what keeps always_comb free of latches.
  always_comb begin
    w_c       = '0;
    o_s_chunk = '0;
    w_c[0]    = i_c_in;
    for (int i = 0; i < CHUNK; i++) begin
      o_s_chunk[i] = i_a_chunk[i] ^ i_b_chunk[i] ^ w_c[i];
      w_c[i+1]     = (i_a_chunk[i] & i_b_chunk[i]) |
                     (i_a_chunk[i] & w_c[i]) |
                     (i_b_chunk[i] & w_c[i]);
    end
  end

  assign o_c_out = w_c[CHUNK];
  assign o_c_msb = w_c[CHUNK-1];

endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit two's-complement adder/subtractor whose carry
// chain is cut into STAGES chunks, one register stage per chunk.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : operand/result stream (slave side), see pipelined_addsub_if
// Stage k adds chunk k using the carry registered by stage k-1. Operand bits
// not yet consumed travel forward with the beat (skew) and finished sum
// chunks travel alongside them (deskew), so the last stage holds the full
// result. The whole pipe advances together whenever the output slot is empty
// or being drained.
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic               clk,
  input logic               rst_n,
  pipelined_addsub_if.slave bus
);

  localparam int CHUNK = WIDTH / STAGES;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_addsub: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  logic             w_advance;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;

  // Per-stage inputs (from the operand port or the previous stage).
  logic [WIDTH-1:0] w_a_in     [STAGES];
  logic [WIDTH-1:0] w_b_in     [STAGES];
  logic [WIDTH-1:0] w_sum_in   [STAGES];
  logic [WIDTH-1:0] w_sum_next [STAGES];
  logic             w_c_in     [STAGES];
  logic             w_v_in     [STAGES];

  // Per-stage chunk adder outputs.
  logic [CHUNK-1:0] w_s     [STAGES];
  logic             w_c_out [STAGES];
  logic             w_c_msb [STAGES];

  // Stage registers.
  logic [WIDTH-1:0] r_a     [STAGES];
  logic [WIDTH-1:0] r_b     [STAGES];
  logic [WIDTH-1:0] r_sum   [STAGES];
  logic             r_c     [STAGES];
  logic             r_valid [STAGES];
  logic             r_ovf;

  // Bubbles shift too, so only a full, blocked output slot stalls the pipe.
  assign w_advance    = bus.out_ready | ~r_valid[STAGES-1];
  assign bus.in_ready = w_advance;

  // Subtract is A + ~B + 1: invert B and force the carry at the entry.
  assign w_b_eff   = (bus.op == OP_SUB) ? ~bus.b : bus.b;
  assign w_cin_eff = (bus.op == OP_SUB) ? 1'b1 : bus.cin;

  always_comb begin : stage_inputs
    w_a_in[0]   = bus.a;
    w_b_in[0]   = w_b_eff;
    w_c_in[0]   = w_cin_eff;
    w_v_in[0]   = bus.in_valid;
    w_sum_in[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      w_a_in[k]   = r_a[k-1];
      w_b_in[k]   = r_b[k-1];
      w_c_in[k]   = r_c[k-1];
      w_v_in[k]   = r_valid[k-1];
      w_sum_in[k] = r_sum[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_chunk
    addsub_chunk #(
      .CHUNK (CHUNK)
    ) u_chunk (
      .i_a_chunk (w_a_in[k][k*CHUNK +: CHUNK]),
      .i_b_chunk (w_b_in[k][k*CHUNK +: CHUNK]),
      .i_c_in    (w_c_in[k]),
      .o_s_chunk (w_s[k]),
      .o_c_out   (w_c_out[k]),
      .o_c_msb   (w_c_msb[k])
    );
  end

  // Drop the freshly computed chunk into its slot of the travelling sum.
  always_comb begin : sum_merge
    for (int k = 0; k < STAGES; k++) begin
      w_sum_next[k]                  = w_sum_in[k];
      w_sum_next[k][k*CHUNK +: CHUNK] = w_s[k];
    end
  end

  // NOTE: data registers are reset along with the valid bits so nothing
  // unknown can ever reach sum/cout/overflow while out_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= 1'b0;
        r_c[k]     <= 1'b0;
        r_a[k]     <= '0;
        r_b[k]     <= '0;
        r_sum[k]   <= '0;
      end
      r_ovf <= 1'b0;
    end else if (w_advance) begin
      // NOTE: non-blocking, so each stage captures its predecessor's value
      // from before this edge regardless of loop order.
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= w_v_in[k];
        r_c[k]     <= w_c_out[k];
        r_a[k]     <= w_a_in[k];
        r_b[k]     <= w_b_in[k];
        r_sum[k]   <= w_sum_next[k];
      end
      // Carry into MSB differs from carry out exactly when the (post-
      // inversion) operand signs agree and the sum sign disagrees.
      r_ovf <= w_c_out[STAGES-1] ^ w_c_msb[STAGES-1];
    end
  end

  assign bus.out_valid = r_valid[STAGES-1];
  assign bus.sum       = r_sum[STAGES-1];
  assign bus.cout      = r_c[STAGES-1];
  assign bus.overflow  = r_ovf;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub. Three instances (STAGES = 4, 1
// and 16, WIDTH = 16) share one operand/ready stimulus; each has its own
// expected-result queue fed by an arithmetic reference model at accept time
// and drained at result handshakes.
module tb_pipelined_addsub;
  import pipelined_addsub_pkg::*;

  localparam int W    = 16;
  localparam int NDUT = 3;
  localparam int SMAX = 2**(W-1) - 1;
  localparam int SMIN = -(2**(W-1));
  localparam int NV   = 9;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  typedef struct {
    logic         op;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    res_t         exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         op;
  logic         cin;
  logic         out_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;

  logic ov  [NDUT];
  logic ir  [NDUT];
  res_t got [NDUT];

  int   n_checks = 0;
  int   n_errors = 0;
  res_t exp_q [NDUT][$];
  res_t got_q [NDUT][$];
  int   accepted [NDUT];
  int   drained  [NDUT];
  logic held     [NDUT];
  logic [W+3:0] prev [NDUT];

  vec_t vecs [NV];

  always #5 clk = ~clk;

  pipelined_addsub_if #(.WIDTH(W)) bus [NDUT] ();

  for (genvar d = 0; d < NDUT; d++) begin : g_dut
    localparam int S = (d == 0) ? 4 : (d == 1) ? 1 : 16;
    pipelined_addsub #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus[d])
    );
    assign bus[d].in_valid  = in_valid;
    assign bus[d].op        = op;
    assign bus[d].cin       = cin;
    assign bus[d].a         = a;
    assign bus[d].b         = b;
    assign bus[d].out_ready = out_ready;
    assign ov[d]  = bus[d].out_valid;
    assign ir[d]  = bus[d].in_ready;
    assign got[d] = {bus[d].sum, bus[d].cout, bus[d].overflow};
  end

  function automatic int stages_of(input int d);
    return (d == 0) ? 4 : (d == 1) ? 1 : 16;
  endfunction

  // Reference: plain unsigned and signed integer arithmetic.
  function automatic res_t model(input logic o, input logic ci,
                                 input logic [W-1:0] x, input logic [W-1:0] y);
    int   ux, uy, sx, sy, ru, rs;
    res_t r;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (o == OP_SUB) begin
      ru     = ux - uy;
      rs     = sx - sy;
      r.cout = (ux >= uy);
    end else begin
      ru     = ux + uy + int'(ci);
      rs     = sx + sy + int'(ci);
      r.cout = (ru > (2**W - 1));
    end
    r.sum = ru[W-1:0];
    r.ovf = (rs > SMAX) || (rs < SMIN);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int d = 0; d < NDUT; d++) s += exp_q[d].size();
    return s;
  endfunction

  task automatic rand_beat();
    op  = 1'($urandom_range(0, 1));
    cin = 1'($urandom_range(0, 1));
    a   = W'($urandom());
    b   = W'($urandom());
    case ($urandom_range(0, 5))
      0: a = {1'b0, {(W-1){1'b1}}};
      1: b = {1'b1, {(W-1){1'b0}}};
      2: a = '1;
      default: ;
    endcase
  endtask

  task automatic flush(input string name);
    int cyc = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (pending() != 0 && cyc < 64) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({name, " drain timeout"}, pending(), 0);
    for (int d = 0; d < NDUT; d++)
      check($sformatf("%s beats in/out dut%0d", name, d), drained[d], accepted[d]);
  endtask

  // Result monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int d = 0; d < NDUT; d++) held[d] = 1'b0;
    end else begin
      for (int d = 0; d < NDUT; d++) begin
        if (held[d]) check($sformatf("stall hold dut%0d", d), {ov[d], got[d]}, prev[d]);
        held[d] = ov[d] && !out_ready;
        prev[d] = {ov[d], got[d]};
        if (ov[d] && out_ready) begin
          drained[d]++;
          got_q[d].push_back(got[d]);
          if (exp_q[d].size() == 0) check($sformatf("spurious beat dut%0d", d), 1, 0);
          else check($sformatf("result dut%0d", d), got[d], exp_q[d].pop_front());
        end
        if (in_valid && ir[d]) begin
          exp_q[d].push_back(model(op, cin, a, b));
          accepted[d]++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat [NDUT];
    int   n;
    int   cyc;
    logic took;
    logic [W+3:0] snap;

    vecs[0] = '{OP_ADD, 1'b0, 16'h7FFF, 16'h0001, {16'h8000, 1'b0, 1'b1}};
    vecs[1] = '{OP_ADD, 1'b0, 16'hFFFF, 16'h0001, {16'h0000, 1'b1, 1'b0}};
    vecs[2] = '{OP_ADD, 1'b1, 16'h1234, 16'h0000, {16'h1235, 1'b0, 1'b0}};
    vecs[3] = '{OP_SUB, 1'b1, 16'h0005, 16'h0007, {16'hFFFE, 1'b0, 1'b0}};
    vecs[4] = '{OP_SUB, 1'b0, 16'h8000, 16'h0001, {16'h7FFF, 1'b1, 1'b1}};
    vecs[5] = '{OP_ADD, 1'b0, 16'h8000, 16'h8000, {16'h0000, 1'b1, 1'b1}};
    vecs[6] = '{OP_SUB, 1'b0, 16'h0000, 16'h8000, {16'h8000, 1'b0, 1'b1}};
    vecs[7] = '{OP_ADD, 1'b1, 16'hFFFF, 16'hFFFF, {16'hFFFF, 1'b1, 1'b0}};
    vecs[8] = '{OP_SUB, 1'b0, 16'h1234, 16'h1234, {16'h0000, 1'b1, 1'b0}};

    rst_n = 1'b0; in_valid = 1'b0; op = 1'b0; cin = 1'b0;
    a = '0; b = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state.
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("reset out_valid dut%0d", d), ov[d], 0);
      check($sformatf("reset outputs dut%0d", d), got[d], 0);
      check($sformatf("reset in_ready dut%0d", d), ir[d], 1);
    end
    @(posedge clk);
    #1;

    // Latency of a single beat (0x7FFF + 1).
    out_ready = 1'b1;
    in_valid = 1'b1; op = vecs[0].op; cin = vecs[0].cin; a = vecs[0].a; b = vecs[0].b;
    for (int d = 0; d < NDUT; d++) lat[d] = 0;
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) in_valid = 1'b0;
      for (int d = 0; d < NDUT; d++) if (ov[d] && lat[d] == 0) lat[d] = c;
    end
    for (int d = 0; d < NDUT; d++)
      check($sformatf("latency dut%0d", d), lat[d], stages_of(d));
    flush("latency");

    // Table vectors, back to back.
    for (int d = 0; d < NDUT; d++) got_q[d].delete();
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1; op = vecs[i].op; cin = vecs[i].cin; a = vecs[i].a; b = vecs[i].b;
      @(posedge clk);
      #1;
    end
    flush("table");
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("table count dut%0d", d), got_q[d].size(), NV);
      for (int i = 0; i < NV && i < got_q[d].size(); i++)
        check($sformatf("table vec%0d dut%0d", i, d), got_q[d][i], vecs[i].exp);
    end

    // Ten random beats with a three-cycle consumer stall mid-stream.
    n = 0; cyc = 0;
    rand_beat();
    in_valid = 1'b1;
    while (n < 10 && cyc < 200) begin
      out_ready = !(cyc >= 6 && cyc < 9);
      @(negedge clk);
      if (cyc >= 6 && cyc < 9) begin
        check("stall in_ready dut0", ir[0], 0);
        if (cyc == 6) snap = {ov[0], got[0]};
        else check("stall outputs dut0", {ov[0], got[0]}, snap);
      end
      took = in_valid && ir[0];
      @(posedge clk);
      #1;
      if (took) begin
        n++;
        rand_beat();
      end
      cyc++;
    end
    in_valid = 1'b0;
    check("stall beats accepted", n, 10);
    flush("stall");

    // Reset with beats in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_beat();
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("pre-reset out_valid dut0", ov[0], 1);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("reset drop out_valid dut%0d", d), ov[d], 0);
      exp_q[d].delete();
      accepted[d] = 0;
      drained[d]  = 0;
    end
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++)
        check($sformatf("post-reset out_valid c%0d dut%0d", c, d), ov[d], 0);
    end
    @(posedge clk);
    #1;

    // Random traffic with random back-pressure.
    for (int c = 0; c < 400; c++) begin
      rand_beat();
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk);
      #1;
    end
    flush("random");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
